// File: rtl/vga_page_display_if.sv
// Signal bundle between the page display, its byte-wide framebuffer RAM and the video sink.
interface vga_page_display_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] RequestedAddress;
  logic [7:0]        DataFromRAM;
  logic              Invert_i;
  logic [2:0]        FgColor_i;
  logic [2:0]        BgColor_i;
  logic              Red_o;
  logic              Green_o;
  logic              Blue_o;
  logic              HSync_o;
  logic              VSync_o;
  logic              FrameStart_o;

  modport master (
    output RequestedAddress, Red_o, Green_o, Blue_o, HSync_o, VSync_o, FrameStart_o,
    input  DataFromRAM, Invert_i, FgColor_i, BgColor_i
  );

  modport slave (
    input  RequestedAddress, Red_o, Green_o, Blue_o, HSync_o, VSync_o, FrameStart_o,
    output DataFromRAM, Invert_i, FgColor_i, BgColor_i
  );
endinterface

// File: rtl/vga_page_display.sv
// VGA timing generator that scales a page-organised 1bpp framebuffer into a centred window.
module vga_page_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SCALE    = 5,
  parameter int FB_W     = 128,
  parameter int FB_H     = 64,
  parameter bit SYNC_POL = 1'b0,
  parameter int ADDR_W   = 10
) (
  input  logic               Clock,
  input  logic               Reset,
  vga_page_display_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int WIN_W   = FB_W * SCALE;
  localparam int WIN_H   = FB_H * SCALE;
  localparam int H_OFF   = (H_ACTIVE - WIN_W) / 2;
  localparam int V_OFF   = (V_ACTIVE - WIN_H) / 2;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW      = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int RW      = $clog2(FB_H);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_OFF_C = HW'(H_OFF);
  localparam logic [HW-1:0] H_END_C = HW'(H_OFF + WIN_W);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_OFF_C = VW'(V_OFF);
  localparam logic [VW-1:0] V_END_C = VW'(V_OFF + WIN_H);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);

  if (WIN_W > H_ACTIVE || WIN_H > V_ACTIVE || (FB_H % 8) != 0 ||
      ADDR_W != $clog2(FB_W * FB_H / 8)) begin : g_bad_params
    $error("vga_page_display: window does not fit, FB_H not a multiple of 8, or ADDR_W wrong");
  end

  function automatic logic [2:0] pix_color(input logic       win,
                                           input logic [7:0] data,
                                           input logic [2:0] sel,
                                           input logic       inv,
                                           input logic [2:0] fg,
                                           input logic [2:0] bg);
    if (!win) return 3'b000;
    return (data[sel] ^ inv) ? fg : bg;
  endfunction

  logic [HW-1:0]     h_p0, h_nxt;
  logic [VW-1:0]     v_p0, v_nxt;
  logic              h_wrap, v_wrap;
  logic              hwin_p0, vwin_p0;
  logic [SW-1:0]     hsub_p0, vsub_p0;
  logic [CW-1:0]     col_p0;
  logic [RW-1:0]     row_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              hs_p0, vs_p0, fs_p0;
  logic              inv_s;
  logic [2:0]        fg_s, bg_s;
  logic              vld_p1, hs_p1, vs_p1, fs_p1;
  logic [2:0]        bit_p1;
  logic              vld_p2, hs_p2, vs_p2, fs_p2;
  logic [2:0]        bit_p2;

  always_comb begin
    h_wrap  = (h_p0 == H_LAST);
    v_wrap  = (v_p0 == V_LAST);
    h_nxt   = h_wrap ? '0 : h_p0 + 1'b1;
    v_nxt   = v_p0;
    if (h_wrap) v_nxt = v_wrap ? '0 : v_p0 + 1'b1;
    addr_p0 = ADDR_W'(32'(row_p0 >> 3) * 32'(FB_W) + 32'(col_p0));
    hs_p0   = (h_p0 >= HS_BEG && h_p0 <= HS_END) ? SYNC_POL : !SYNC_POL;
    vs_p0   = (v_p0 >= VS_BEG && v_p0 <= VS_END) ? SYNC_POL : !SYNC_POL;
    fs_p0   = (h_p0 == '0) && (v_p0 == '0);
  end

  // Stage p0: raster counters plus column/row dividers that step once every SCALE clocks/lines
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      h_p0    <= '0;
      v_p0    <= '0;
      hwin_p0 <= (H_OFF == 0);
      vwin_p0 <= (V_OFF == 0);
      hsub_p0 <= '0;
      col_p0  <= '0;
      vsub_p0 <= '0;
      row_p0  <= '0;
    end else begin
      h_p0 <= h_nxt;
      v_p0 <= v_nxt;
      if (h_nxt == H_OFF_C) begin
        hwin_p0 <= 1'b1;
        hsub_p0 <= '0;
        col_p0  <= '0;
      end else begin
        if (h_nxt == H_END_C) hwin_p0 <= 1'b0;
        if (hwin_p0) begin
          if (hsub_p0 == S_LAST) begin
            hsub_p0 <= '0;
            col_p0  <= col_p0 + 1'b1;
          end else begin
            hsub_p0 <= hsub_p0 + 1'b1;
          end
        end
      end
      if (h_wrap) begin
        if (v_nxt == V_OFF_C) begin
          vwin_p0 <= 1'b1;
          vsub_p0 <= '0;
          row_p0  <= '0;
        end else begin
          if (v_nxt == V_END_C) vwin_p0 <= 1'b0;
          if (vwin_p0) begin
            if (vsub_p0 == S_LAST) begin
              vsub_p0 <= '0;
              row_p0  <= row_p0 + 1'b1;
            end else begin
              vsub_p0 <= vsub_p0 + 1'b1;
            end
          end
        end
      end
    end
  end

  // Frame-level attributes are latched only at the top-left counter position
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inv_s <= 1'b0;
      fg_s  <= 3'b000;
      bg_s  <= 3'b000;
    end else if (fs_p0) begin
      inv_s <= bus.Invert_i;
      fg_s  <= bus.FgColor_i;
      bg_s  <= bus.BgColor_i;
    end
  end

  // Stage p1: address presented to RAM; held outside the window
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bus.RequestedAddress <= '0;
      vld_p1 <= 1'b0;
      bit_p1 <= 3'b000;
      hs_p1  <= !SYNC_POL;
      vs_p1  <= !SYNC_POL;
      fs_p1  <= 1'b0;
    end else begin
      if (hwin_p0 && vwin_p0) bus.RequestedAddress <= addr_p0;
      vld_p1 <= hwin_p0 && vwin_p0;
      bit_p1 <= row_p0[2:0];
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      fs_p1  <= fs_p0;
    end
  end

  // Stage p2: RAM byte arrives; controls ride along to stay aligned with it
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vld_p2 <= 1'b0;
      bit_p2 <= 3'b000;
      hs_p2  <= !SYNC_POL;
      vs_p2  <= !SYNC_POL;
      fs_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      bit_p2 <= bit_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      fs_p2  <= fs_p1;
    end
  end

  // Output stage: colour and syncs registered together
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      {bus.Red_o, bus.Green_o, bus.Blue_o} <= 3'b000;
      bus.HSync_o      <= !SYNC_POL;
      bus.VSync_o      <= !SYNC_POL;
      bus.FrameStart_o <= 1'b0;
    end else begin
      {bus.Red_o, bus.Green_o, bus.Blue_o} <=
        pix_color(vld_p2, bus.DataFromRAM, bit_p2, inv_s, fg_s, bg_s);
      bus.HSync_o      <= hs_p2;
      bus.VSync_o      <= vs_p2;
      bus.FrameStart_o <= fs_p2;
    end
  end

endmodule

// File: tb/tb_vga_page_display.sv
// Scoreboard bench for vga_page_display on a reduced raster so several frames fit a short run.
module tb_vga_page_display;

  localparam int H_ACTIVE = 40, H_FRONT = 4, H_SYNC = 6, H_BACK = 6;
  localparam int V_ACTIVE = 36, V_FRONT = 2, V_SYNC = 2, V_BACK = 3;
  localparam int SCALE = 2, FB_W = 12, FB_H = 16, AW = 5;
  // Hand-derived raster constants for the parameter set above
  localparam int H_TOTAL = 56, V_TOTAL = 43;
  localparam int H_OFF = 8, V_OFF = 2;
  localparam int HS_BEG = 44, HS_END = 49, VS_BEG = 38, VS_END = 39;
  localparam logic [5:0] RST_PIX = 6'b011000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_page_display_if #(.ADDR_W(AW)) bus ();

  vga_page_display #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SCALE(SCALE), .FB_W(FB_W), .FB_H(FB_H), .SYNC_POL(1'b0), .ADDR_W(AW)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus.master)
  );

  logic [7:0] ram [0:31];
  always @(posedge clk) bus.DataFromRAM <= ram[bus.RequestedAddress];

  int          checks = 0;
  int          errors = 0;
  logic [5:0]  exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic        mon_en  = 1'b0;
  int          rel_gen = 0;

  int          mh, mv, frame;
  logic        m_inv;
  logic [2:0]  m_fg, m_bg;
  logic [AW-1:0] m_addr;

  function automatic logic [5:0] model_pix(input int h, input int v, input logic inv,
                                           input logic [2:0] fg, input logic [2:0] bg);
    logic [2:0] rgb;
    logic [7:0] b;
    logic hs, vs, fs;
    int col, row;
    rgb = 3'b000;
    if (h >= H_OFF && h < H_OFF + FB_W * SCALE && v >= V_OFF && v < V_OFF + FB_H * SCALE) begin
      col = (h - H_OFF) / SCALE;
      row = (v - V_OFF) / SCALE;
      b   = ram[(row / 8) * FB_W + col];
      rgb = (b[row % 8] ^ inv) ? fg : bg;
    end
    hs = (h >= HS_BEG && h <= HS_END) ? 1'b0 : 1'b1;
    vs = (v >= VS_BEG && v <= VS_END) ? 1'b0 : 1'b1;
    fs = (h == 0 && v == 0);
    return {fs, vs, hs, rgb};
  endfunction

  task automatic push_pixel();
    if (mh == 0 && mv == 0) begin
      m_inv = bus.Invert_i;
      m_fg  = bus.FgColor_i;
      m_bg  = bus.BgColor_i;
    end
    exp_q.push_back(model_pix(mh, mv, m_inv, m_fg, m_bg));
    if (mh >= H_OFF && mh < H_OFF + FB_W * SCALE && mv >= V_OFF && mv < V_OFF + FB_H * SCALE)
      m_addr = AW'((((mv - V_OFF) / SCALE) / 8) * FB_W + (mh - H_OFF) / SCALE);
    addr_q.push_back(m_addr);
  endtask

  task automatic advance();
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      if (mv == V_TOTAL - 1) begin
        mv = 0;
        frame++;
      end else begin
        mv++;
      end
    end else begin
      mh++;
    end
  endtask

  // Called at a falling clock edge; the DUT's counters show (0,0) until the next rising edge
  task automatic release_reset();
    exp_q.delete();
    addr_q.delete();
    mh = 0; mv = 0; frame = 0; m_addr = '0;
    rst_n = 1'b1;
    exp_q.push_back(RST_PIX);
    exp_q.push_back(RST_PIX);
    push_pixel();
    rel_gen++;
    mon_en = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: reset values whenever reset is low, otherwise scoreboard pops every clock
  initial begin
    int k;
    int gen;
    bit hs_seen;
    logic [5:0] e;
    logic [AW-1:0] ea;
    k = 0; gen = 0; hs_seen = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        check("reset_state",
              32'({bus.RequestedAddress, bus.FrameStart_o, bus.VSync_o, bus.HSync_o,
                   bus.Red_o, bus.Green_o, bus.Blue_o}),
              32'({{AW{1'b0}}, RST_PIX}));
      end else if (mon_en) begin
        if (gen != rel_gen) begin
          gen = rel_gen; k = 0; hs_seen = 1'b0;
        end
        k++;
        if (exp_q.size() == 0) begin
          check("pixel_queue_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pixel_fs_vs_hs_rgb",
                32'({bus.FrameStart_o, bus.VSync_o, bus.HSync_o, bus.Red_o, bus.Green_o, bus.Blue_o}),
                32'(e));
        end
        if (addr_q.size() == 0) begin
          check("addr_queue_empty", 32'(addr_q.size()), 32'd1);
        end else begin
          ea = addr_q.pop_front();
          check("requested_address", 32'(bus.RequestedAddress), 32'(ea));
        end
        if (!hs_seen) begin
          if (bus.HSync_o == 1'b0) begin
            hs_seen = 1'b1;
            check("first_hsync_clocks_after_release", 32'(k), 32'(HS_BEG + 3));
          end else if (k > H_TOTAL + 5) begin
            hs_seen = 1'b1;
            check("first_hsync_timeout", 32'(k), 32'(HS_BEG + 3));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Stimulus: frame 0 plain 0x01 RAM, frame 1 new pattern/colours, invert mid frame 1, reset mid frame 2
  initial begin
    int phase;
    bit done;
    phase = 0; done = 1'b0;
    mh = 0; mv = 0; frame = 0; m_inv = 1'b0; m_fg = 3'b000; m_bg = 3'b000; m_addr = '0;
    bus.Invert_i  = 1'b0;
    bus.FgColor_i = 3'b111;
    bus.BgColor_i = 3'b000;
    for (int i = 0; i < 32; i++) ram[i] = 8'h01;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    release_reset();
    while (!done) begin
      @(negedge clk);
      advance();
      if (phase == 0 && frame == 0 && mv == V_ACTIVE && mh == 0) begin
        for (int i = 0; i < 32; i++) ram[i] = 8'(i * 37 + 5);
        bus.FgColor_i = 3'b101;
        bus.BgColor_i = 3'b010;
        phase = 1;
      end else if (phase == 1 && frame == 1 && mv == 20 && mh == 15) begin
        bus.Invert_i  = 1'b1;
        bus.FgColor_i = 3'b011;
        phase = 2;
      end else if (phase == 2 && frame == 2 && mv == 12 && mh == 20) begin
        mon_en = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        release_reset();
        phase = 3;
        continue;
      end else if (phase == 3 && frame == 2) begin
        done = 1'b1;
      end
      if (!done) push_pixel();
    end
    mon_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_page_display.md
VGA_PAGE_DISPLAY -- requirements
Module: vga_page_display

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 Parameter SCALE, default 5, screen pixels per framebuffer pixel in each axis.
REQ-006 Parameters FB_W/FB_H, defaults 128/64, framebuffer size in pixels; FB_H a multiple of 8.
REQ-007 Parameter SYNC_POL, default 0, active level of both sync outputs.
REQ-008 Parameter ADDR_W, default 10, RAM address width, equal to clog2(FB_W*FB_H/8).
REQ-009 Clock  in  1  pixel clock, rising edge.
REQ-010 Reset  in  1  asynchronous, active-low reset.
REQ-011 RequestedAddress  out  ADDR_W  registered byte address to the page-organised RAM.
REQ-012 DataFromRAM  in  8  byte at the address presented on the previous clock (1-cycle synchronous read).
REQ-013 Invert_i  in  1  1 = swap foreground/background.
REQ-014 FgColor_i / BgColor_i  in  3 each  {R,G,B} colour for set/clear bits.
REQ-015 Red_o, Green_o, Blue_o  out  1 each  registered colour.
REQ-016 HSync_o, VSync_o  out  1 each  registered syncs.
REQ-017 FrameStart_o  out  1  one-clock pulse, first pixel of each frame.

Function
REQ-018 H counter SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap; V counter SHALL advance on H wrap, count 0..V_TOTAL-1 and wrap.
REQ-019 Sync SHALL be active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] and v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]; inactive otherwise.
REQ-020 Window SHALL be centred: H_OFF=(H_ACTIVE-FB_W*SCALE)/2, V_OFF=(V_ACTIVE-FB_H*SCALE)/2.
REQ-021 Inside window: col=(h-H_OFF)/SCALE, row=(v-V_OFF)/SCALE, computed with divider counters (no arithmetic divide); address=(row>>3)*FB_W+col; bit=row[2:0].
REQ-022 Pixel colour SHALL be FgColor if DataFromRAM[bit] XOR inv =1, else BgColor; active area outside window and all blanking SHALL be 000.
REQ-023 Invert_i, FgColor_i, BgColor_i SHALL be sampled only at h=0,v=0; changes take effect next frame.
REQ-024 Pipeline: counters (h,v) in cycle N, address registered N+1, data N+2, colour and syncs for (h,v) on outputs in cycle N+3; syncs delayed identically.
REQ-025 RequestedAddress SHALL hold its last value outside the window.
REQ-026 FrameStart_o SHALL pulse in the cycle the outputs show (0,0).
REQ-027 Parameter sets with FB_W*SCALE>H_ACTIVE, FB_H*SCALE>V_ACTIVE or FB_H%8≠0 SHALL fail elaboration.

Reset
REQ-028 While Reset=0: counters, dividers, pipeline 0; RequestedAddress 0; colour 000; syncs at !SYNC_POL; FrameStart_o 0; sampled Invert/colours 0.
REQ-029 Reset assertion mid-line SHALL force REQ-028 values immediately; after release, counters start at (0,0) on the first edge.

Verification
REQ-030 Defaults, run 2 frames -> HSync_o low 96 clocks, period 800; VSync_o low 1600 clocks, period 420000; FrameStart_o once per 420000.
REQ-031 RAM all 0x01, Fg=111, Bg=000 -> lines 80-84, 120-124, ..., 360-364 white for h 0..639; all other lines black.
REQ-032 Address sweep, defaults -> v=80: RequestedAddress 0..127, each held 5 clocks; v=120 starts at 128; v=395..399 covers 896..1023.
REQ-033 Invert_i toggled at v=200 -> current frame unchanged; next frame all pixels in window swapped; border stays 000.
REQ-034 SCALE=4, FB_W=128, FB_H=32, ADDR_W=9 -> H_OFF=64, V_OFF=176; h<64 or v<176 black; first address 0 at h=64,v=176.
REQ-035 Reset pulsed at h=300,v=100 -> outputs 000, syncs 1 within the same cycle; first HSync low 659 clocks after release.
